// File: rtl/bitwise_logic_unit.sv
// Registered NUM_IN-lane bitwise reducer behind a one-entry valid/ready output stage.
// Each result carries the cycle timestamp and sequence number of its acceptance.
module bitwise_logic_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_IN    = 2,
  parameter int unsigned TS_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [TS_WIDTH-1:0]     out_timestamp,
  output logic [CNT_WIDTH-1:0]    out_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
    $error("bitwise_logic_unit: NUM_IN must be in the range 2..8");
  end

  logic [WIDTH-1:0] lane    [NUM_IN];
  logic [WIDTH-1:0] and_chain [NUM_IN];
  logic [WIDTH-1:0] or_chain  [NUM_IN];
  logic [WIDTH-1:0] xor_chain [NUM_IN];

  // Running reductions: entry gi holds the reduction of lanes 0..gi.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign lane[gi] = in_data[gi*WIDTH +: WIDTH];
    if (gi == 0) begin : g_first
      assign and_chain[gi] = lane[gi];
      assign or_chain[gi]  = lane[gi];
      assign xor_chain[gi] = lane[gi];
    end else begin : g_rest
      assign and_chain[gi] = and_chain[gi-1] & lane[gi];
      assign or_chain[gi]  = or_chain[gi-1]  | lane[gi];
      assign xor_chain[gi] = xor_chain[gi-1] ^ lane[gi];
    end
  end

  logic [WIDTH-1:0] and_red;
  logic [WIDTH-1:0] or_red;
  logic [WIDTH-1:0] xor_red;

  assign and_red = and_chain[NUM_IN-1];
  assign or_red  = or_chain[NUM_IN-1];
  assign xor_red = xor_chain[NUM_IN-1];

  logic [WIDTH-1:0] result;
  logic             result_err;

  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (op_e'(op))
      OP_AND:  result = and_red;
      OP_OR:   result = or_red;
      OP_XOR:  result = xor_red;
      OP_NAND: result = ~and_red;
      OP_NOR:  result = ~or_red;
      OP_XNOR: result = ~xor_red;
      OP_PASS: result = lane[0];
      default: result_err = 1'b1;
    endcase
  end

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 err_q, err_d;
  logic [TS_WIDTH-1:0]  stamp_q, stamp_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] seq_q, seq_d;
  logic                 acc;

  // Ready depends only on the stage state and the consumer, never on in_valid.
  assign in_ready = ~valid_q | out_ready;
  assign acc      = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    stamp_d = stamp_q;
    count_d = count_q;
    seq_d   = seq_q;
    ts_d    = ts_q + TS_WIDTH'(1);
    if (acc) begin
      valid_d = 1'b1;
      data_d  = result;
      err_d   = result_err;
      stamp_d = ts_q;
      count_d = seq_q;
      seq_d   = seq_q + CNT_WIDTH'(1);
    end else if (out_ready) begin
      // Drain leaves the payload registers untouched.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      stamp_q <= '0;
      count_q <= '0;
      ts_q    <= '0;
      seq_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      stamp_q <= stamp_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      seq_q   <= seq_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_err       = err_q;
  assign out_timestamp = stamp_q;
  assign out_count     = count_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomised and directed bench for bitwise_logic_unit (4 lanes, 4-bit timestamp, 3-bit count)
// checked against a per-bit lane-counting reference model.
module tb_bitwise_logic_unit;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TSW = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_err;
  logic [TSW-1:0] out_timestamp;
  logic [CW-1:0]  out_count;

  bitwise_logic_unit #(.WIDTH(W), .NUM_IN(N), .TS_WIDTH(TSW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .out_timestamp(out_timestamp),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic           m_err;
  logic [TSW-1:0] m_ts;
  logic [CW-1:0]  m_cnt;
  logic [CW-1:0]  seq;
  logic [TSW-1:0] cyc;

  // Each result bit is decided by how many lanes have that bit set.
  function automatic logic [W:0] ref_op(input logic [N*W-1:0] d, input logic [2:0] o);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      int ones;
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(d[k*W + b]);
      case (o)
        3'd0: r[b] = (ones == N);
        3'd1: r[b] = (ones > 0);
        3'd2: r[b] = (ones % 2 == 1);
        3'd3: r[b] = (ones != N);
        3'd4: r[b] = (ones == 0);
        3'd5: r[b] = (ones % 2 == 0);
        3'd6: r[b] = d[b];
        default: r[b] = 1'b0;
      endcase
    end
    return {(o == 3'd7), r};
  endfunction

  function automatic void model_clear();
    m_valid = 1'b0; m_data = '0; m_err = 1'b0; m_ts = '0; m_cnt = '0;
    seq = '0; cyc = '0;
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic tick();
    logic [W:0] res;
    if (rst_n && in_valid && (!m_valid || out_ready)) begin
      res     = ref_op(in_data, op);
      m_valid = 1'b1;
      m_err   = res[W];
      m_data  = res[W-1:0];
      m_ts    = cyc;
      m_cnt   = seq;
      seq     = seq + 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (rst_n) cyc = cyc + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; op = '0; out_ready = 1'b0;
    model_clear();
    #12;
    n_vec++;
    if ({out_valid, out_data, out_err, out_timestamp, out_count, in_ready} !== {1'b0, 8'h00, 1'b0, 4'h0, 3'h0, 1'b1}) begin
      n_miss++;
      $display("FAIL reset_state: got v=%0b d=%h e=%0b ts=%0d c=%0d rdy=%0b, want zeros with rdy=1",
               out_valid, out_data, out_err, out_timestamp, out_count, in_ready);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL post_reset_idle: got rdy=%0b v=%0b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic_and();
    in_valid = 1'b1; op = 3'd0; out_ready = 1'b1;
    in_data = {8'hFF, 8'hFF, 8'h3C, 8'hF0};
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_data, out_err, out_count} !== {1'b1, 8'h30, 1'b0, 3'd0} || out_timestamp !== m_ts) begin
      n_miss++;
      $display("FAIL basic_and: got v=%0b d=%h e=%0b c=%0d ts=%0d, want v=1 d=30 e=0 c=0 ts=%0d",
               out_valid, out_data, out_err, out_count, out_timestamp, m_ts);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]     ops  [4] = '{3'd1, 3'd2, 3'd4, 3'd6};
    logic [W-1:0]   want [4] = '{8'h0F, 8'h0F, 8'hF0, 8'h01};
    logic [TSW-1:0] first_ts;
    do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    in_data = {8'h08, 8'h04, 8'h02, 8'h01};
    in_valid = 1'b1;
    first_ts = '0;
    for (int i = 0; i < 4; i++) begin
      op = ops[i];
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL b2b_ready[%0d]: got %0b want 1", i, in_ready);
      end
      tick();
      if (i == 0) first_ts = out_timestamp;
      n_vec++;
      if ({out_valid, out_data, out_err, out_count} !== {1'b1, want[i], 1'b0, 3'(i)} ||
          out_timestamp !== first_ts + 4'(i) || out_timestamp !== m_ts) begin
        n_miss++;
        $display("FAIL b2b_result[%0d]: got v=%0b d=%h e=%0b c=%0d ts=%0d, want v=1 d=%h e=0 c=%0d ts=%0d",
                 i, out_valid, out_data, out_err, out_count, out_timestamp, want[i], i, m_ts);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [W-1:0]   d0;
    logic [CW-1:0]  c0;
    logic [TSW-1:0] t0;
    d0 = out_data; c0 = out_count; t0 = out_timestamp;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== d0 || out_count !== c0 || out_timestamp !== t0 ||
        out_data !== m_data) begin
      n_miss++;
      $display("FAIL drain: got v=%0b d=%h c=%0d ts=%0d, want v=0 d=%h c=%0d ts=%0d",
               out_valid, out_data, out_count, out_timestamp, m_data, m_cnt, m_ts);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; op = 3'd3; out_ready = 1'b0;
    in_data = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom; op = 3'($urandom);
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_miss++;
        $display("FAIL hold_ready[%0d]: got %0b want 0", i, in_ready);
      end
      tick();
      n_vec++;
      if ({out_valid, out_data, out_err, out_count, out_timestamp} !== {1'b1, 8'h00, 1'b0, m_cnt, m_ts}) begin
        n_miss++;
        $display("FAIL hold_stable[%0d]: got v=%0b d=%h e=%0b c=%0d ts=%0d, want v=1 d=00 e=0 c=%0d ts=%0d",
                 i, out_valid, out_data, out_err, out_count, out_timestamp, m_cnt, m_ts);
      end
    end
    out_ready = 1'b1; op = 3'd1; in_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL reload_ready: got %0b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_data, out_err, out_count, out_timestamp} !== {1'b1, 8'h5A, 1'b0, m_cnt, m_ts}) begin
      n_miss++;
      $display("FAIL reload: got v=%0b d=%h c=%0d ts=%0d, want v=1 d=5a c=%0d ts=%0d",
               out_valid, out_data, out_count, out_timestamp, m_cnt, m_ts);
    end
  endtask

  task automatic test_reserved();
    logic [CW-1:0] prev;
    prev = out_count;
    in_valid = 1'b1; op = 3'd7; out_ready = 1'b1; in_data = $urandom;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_data, out_err} !== {1'b1, 8'h00, 1'b1} || out_count !== prev + 1'b1 ||
        out_count !== m_cnt) begin
      n_miss++;
      $display("FAIL reserved_op: got v=%0b d=%h e=%0b c=%0d, want v=1 d=00 e=1 c=%0d",
               out_valid, out_data, out_err, out_count, m_cnt);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; op = 3'd2; out_ready = 1'b0; in_data = $urandom;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if ({out_valid, out_data, out_err, out_timestamp, out_count} !== '0) begin
      n_miss++;
      $display("FAIL async_reset: got v=%0b d=%h e=%0b ts=%0d c=%0d, want all zero",
               out_valid, out_data, out_err, out_timestamp, out_count);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; op = 3'd6; out_ready = 1'b1; in_data = {24'h0, 8'hA5};
    tick();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_data, out_count} !== {1'b1, 8'hA5, 3'd0} || out_timestamp !== 4'd0) begin
      n_miss++;
      $display("FAIL post_async_reset: got v=%0b d=%h c=%0d ts=%0d, want v=1 d=a5 c=0 ts=0",
               out_valid, out_data, out_count, out_timestamp);
    end
  endtask

  task automatic test_wrap();
    bit ts_wrap = 0, cnt_wrap = 0;
    logic [TSW-1:0] pts;
    logic [CW-1:0]  pcnt;
    in_valid = 1'b1; out_ready = 1'b1;
    pts = out_timestamp; pcnt = out_count;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom; op = 3'($urandom);
      tick();
      n_vec++;
      if ({out_valid, out_data, out_err, out_timestamp, out_count} !== {m_valid, m_data, m_err, m_ts, m_cnt}) begin
        n_miss++;
        $display("FAIL wrap_vec[%0d]: got v=%0b d=%h e=%0b ts=%0d c=%0d, want v=%0b d=%h e=%0b ts=%0d c=%0d",
                 i, out_valid, out_data, out_err, out_timestamp, out_count,
                 m_valid, m_data, m_err, m_ts, m_cnt);
      end
      if (pts == 4'd15 && out_timestamp == 4'd0) ts_wrap = 1;
      if (pcnt == 3'd7 && out_count == 3'd0) cnt_wrap = 1;
      pts = out_timestamp; pcnt = out_count;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!ts_wrap || !cnt_wrap) begin
      n_miss++;
      $display("FAIL wrap_seen: got ts_wrap=%0b cnt_wrap=%0b, want both 1", ts_wrap, cnt_wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = $urandom;
      op        = 3'($urandom);
      #1;
      n_vec++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_miss++;
        $display("FAIL rand_ready[%0d]: got %0b want %0b", i, in_ready, (!m_valid || out_ready));
      end
      tick();
      n_vec++;
      if ({out_valid, out_data, out_err, out_timestamp, out_count} !== {m_valid, m_data, m_err, m_ts, m_cnt}) begin
        n_miss++;
        $display("FAIL rand_vec[%0d]: got v=%0b d=%h e=%0b ts=%0d c=%0d, want v=%0b d=%h e=%0b ts=%0d c=%0d",
                 i, out_valid, out_data, out_err, out_timestamp, out_count,
                 m_valid, m_data, m_err, m_ts, m_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_and();
    test_back_to_back();
    test_drain();
    test_backpressure();
    test_reserved();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
